// File: rtl/gol_pkg.sv
// rtl/gol_pkg.sv - shared types, defaults and helpers for the Game of Life engine
package gol_pkg;

    localparam int DEF_GRID_W = 16;
    localparam int DEF_GRID_H = 16;

    // Largest image the seed helper can build (32 x 32 grid).
    localparam int MAX_CELLS = 1024;

    typedef enum logic {
        IDLE = 1'b0,
        CALC = 1'b1
    } gol_state_e;

    // Glider image for a grid of width w; bit index is y*w+x.
    function automatic logic [MAX_CELLS-1:0] glider_image(input int w);
        logic [MAX_CELLS-1:0] img;
        img            = '0;
        img[1]         = 1'b1;
        img[w + 2]     = 1'b1;
        img[2 * w]     = 1'b1;
        img[2 * w + 1] = 1'b1;
        img[2 * w + 2] = 1'b1;
        return img;
    endfunction

    localparam logic [DEF_GRID_W*DEF_GRID_H-1:0] GLIDER_SEED =
        (DEF_GRID_W*DEF_GRID_H)'(glider_image(DEF_GRID_W));

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] c;
        c = '0;
        for (int i = 0; i < 8; i++) begin
            c = c + {3'b000, v[i]};
        end
        return c;
    endfunction

endpackage

// File: rtl/gol_row_update.sv
// rtl/gol_row_update.sv - combinational B3/S23 next-row computation with wrapping columns
//
// Ports:
//   above - row above the row being updated
//   cur   - row being updated
//   below - row below the row being updated
//   next  - next-generation contents of cur
module gol_row_update
    import gol_pkg::*;
#(
    parameter int GRID_W = DEF_GRID_W
) (
    input  logic [GRID_W-1:0] above,
    input  logic [GRID_W-1:0] cur,
    input  logic [GRID_W-1:0] below,
    output logic [GRID_W-1:0] next
);

    for (genvar x = 0; x < GRID_W; x++) begin : g_col
        // Left/right neighbours wrap around the row ends.
        localparam int XL = (x + GRID_W - 1) % GRID_W;
        localparam int XR = (x + 1) % GRID_W;

        logic [3:0] n;

        assign n = popcount8({above[XL], above[x], above[XR],
                              cur[XL],             cur[XR],
                              below[XL], below[x], below[XR]});

        assign next[x] = (n == 4'd3) | (cur[x] & (n == 4'd2));
    end

endmodule

// File: rtl/gol_life_engine.sv
// rtl/gol_life_engine.sv - toroidal Game of Life grid with row-serial in-place generation step
//
// Ports:
//   clk, rst         - clock, synchronous active-high reset
//   start            - request one generation (accepted in IDLE without wr_en)
//   busy, done       - generation in progress / one-cycle completion pulse
//   gen_count        - completed generations, wrapping
//   extinct          - grid all-dead flag
//   wr_en/row/data   - row write port, honoured in IDLE
//   rd_x, rd_y       - combinational cell read address
//   rd_cell          - grid[rd_y][rd_x]
module gol_life_engine
    import gol_pkg::*;
#(
    parameter int GRID_W = DEF_GRID_W,
    parameter int GRID_H = DEF_GRID_H,
    parameter logic [GRID_W*GRID_H-1:0] SEED = (GRID_W*GRID_H)'(glider_image(GRID_W))
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    output logic                      busy,
    output logic                      done,
    output logic [15:0]               gen_count,
    output logic                      extinct,
    input  logic                      wr_en,
    input  logic [$clog2(GRID_H)-1:0] wr_row,
    input  logic [GRID_W-1:0]         wr_data,
    input  logic [$clog2(GRID_W)-1:0] rd_x,
    input  logic [$clog2(GRID_H)-1:0] rd_y,
    output logic                      rd_cell
);

    localparam int YW = $clog2(GRID_H);

    gol_state_e        state_q, state_d;
    logic [YW-1:0]     row_q;
    logic [GRID_W-1:0] grid_q [GRID_H];
    logic [GRID_W-1:0] row0_old_q;
    logic [GRID_W-1:0] prev_old_q;
    logic [GRID_W-1:0] below_row;
    logic [GRID_W-1:0] next_row;
    logic              done_q;
    logic              extinct_q;
    logic              wr_pend_q;
    logic [15:0]       gen_q;
    logic              last_row;
    logic              start_acc;
    logic              all_dead;
    logic              post_dead;

    assign last_row  = (row_q == YW'(GRID_H - 1));
    assign start_acc = (state_q == IDLE) && start && !wr_en;

    // Rows are overwritten in place, so the original top row and the original
    // row above the current one are kept aside in row0_old_q / prev_old_q.
    assign below_row = last_row ? row0_old_q : grid_q[row_q + YW'(1)];

    gol_row_update #(
        .GRID_W (GRID_W)
    ) u_row_update (
        .above (prev_old_q),
        .cur   (grid_q[row_q]),
        .below (below_row),
        .next  (next_row)
    );

    // all_dead: current storage; post_dead: storage once the row under
    // calculation has been replaced (used at the final row write).
    always_comb begin
        all_dead  = 1'b1;
        post_dead = 1'b1;
        for (int y = 0; y < GRID_H; y++) begin
            if (grid_q[y] != '0) begin
                all_dead = 1'b0;
            end
            if (YW'(y) == row_q) begin
                if (next_row != '0) begin
                    post_dead = 1'b0;
                end
            end else if (grid_q[y] != '0) begin
                post_dead = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_acc) state_d = CALC;
            CALC:    if (last_row)  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == CALC);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int y = 0; y < GRID_H; y++) begin
                grid_q[y] <= SEED[y*GRID_W +: GRID_W];
            end
            row_q      <= '0;
            row0_old_q <= '0;
            prev_old_q <= '0;
            done_q     <= 1'b0;
            gen_q      <= '0;
            extinct_q  <= (SEED == '0);
            wr_pend_q  <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            wr_pend_q <= 1'b0;
            if (state_q == IDLE) begin
                if (wr_en) begin
                    grid_q[wr_row] <= wr_data;
                    wr_pend_q      <= 1'b1;
                end else if (start) begin
                    row_q      <= '0;
                    row0_old_q <= grid_q[0];
                    prev_old_q <= grid_q[GRID_H-1];
                end
                if (wr_pend_q) begin
                    extinct_q <= all_dead;
                end
            end else begin
                grid_q[row_q] <= next_row;
                prev_old_q    <= grid_q[row_q];
                row_q         <= row_q + YW'(1);
                if (last_row) begin
                    done_q    <= 1'b1;
                    gen_q     <= gen_q + 16'd1;
                    extinct_q <= post_dead;
                end
            end
        end
    end

    assign done      = done_q;
    assign gen_count = gen_q;
    assign extinct   = extinct_q;
    assign rd_cell   = grid_q[rd_y][rd_x];

endmodule

// File: tb/tb_gol_life_engine.sv
// tb/tb_gol_life_engine.sv - directed self-checking bench for gol_life_engine
`timescale 1ns/1ps
module tb_gol_life_engine;

    logic        clk     = 1'b0;
    logic        rst     = 1'b1;
    logic        start   = 1'b0;
    logic        wr_en   = 1'b0;
    logic [3:0]  wr_row  = '0;
    logic [15:0] wr_data = '0;
    logic [3:0]  rd_x    = '0;
    logic [3:0]  rd_y    = '0;
    logic        busy;
    logic        done;
    logic        extinct;
    logic        rd_cell;
    logic [15:0] gen_count;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    gol_life_engine dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .gen_count (gen_count),
        .extinct   (extinct),
        .wr_en     (wr_en),
        .wr_row    (wr_row),
        .wr_data   (wr_data),
        .rd_x      (rd_x),
        .rd_y      (rd_y),
        .rd_cell   (rd_cell)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic read_row(input int y, output logic [15:0] v);
        for (int x = 0; x < 16; x++) begin
            rd_y = 4'(y);
            rd_x = 4'(x);
            #0.5;
            v[x] = rd_cell;
        end
    endtask

    function automatic logic [15:0] seed_row(input int y);
        case (y)
            0:       return 16'h0002;
            1:       return 16'h0004;
            2:       return 16'h0007;
            default: return 16'h0000;
        endcase
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic write_row(input int y, input logic [15:0] d);
        wr_en   = 1'b1;
        wr_row  = 4'(y);
        wr_data = d;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic clear_grid();
        for (int y = 0; y < 16; y++) write_row(y, 16'h0000);
    endtask

    // Returns number of sampled cycles with busy high after start accepted.
    task automatic run_gen(output int n);
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            n++;
            tick();
        end
    endtask

    task automatic test_reset();
        logic [15:0] v;
        do_reset();
        for (int y = 0; y < 16; y++) begin
            read_row(y, v);
            checks++;
            if (v !== seed_row(y)) begin
                errors++;
                $display("FAIL reset_row%0d got=%h exp=%h", y, v, seed_row(y));
            end
        end
        checks++;
        if (gen_count !== 16'd0) begin errors++; $display("FAIL reset_gen got=%0d exp=0", gen_count); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++;
        if (extinct !== 1'b0) begin errors++; $display("FAIL reset_extinct got=%b exp=0", extinct); end
    endtask

    task automatic test_blinker();
        logic [15:0] v;
        int n;
        do_reset();
        clear_grid();
        write_row(5, 16'h0038);
        tick();
        run_gen(n);
        checks++;
        if (n !== 16) begin errors++; $display("FAIL blinker_busy_cycles got=%0d exp=16", n); end
        checks++;
        if (done !== 1'b1) begin errors++; $display("FAIL blinker_done got=%b exp=1", done); end
        tick();
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL blinker_done_pulse got=%b exp=0", done); end
        for (int y = 3; y <= 7; y++) begin
            read_row(y, v);
            checks++;
            if (v !== ((y >= 4 && y <= 6) ? 16'h0010 : 16'h0000)) begin
                errors++;
                $display("FAIL blinker_g1_row%0d got=%h exp=%h", y, v,
                         (y >= 4 && y <= 6) ? 16'h0010 : 16'h0000);
            end
        end
        checks++;
        if (gen_count !== 16'd1) begin errors++; $display("FAIL blinker_gen1 got=%0d exp=1", gen_count); end
        run_gen(n);
        read_row(5, v);
        checks++;
        if (v !== 16'h0038) begin errors++; $display("FAIL blinker_g2_row5 got=%h exp=0038", v); end
        read_row(4, v);
        checks++;
        if (v !== 16'h0000) begin errors++; $display("FAIL blinker_g2_row4 got=%h exp=0000", v); end
        checks++;
        if (gen_count !== 16'd2) begin errors++; $display("FAIL blinker_gen2 got=%0d exp=2", gen_count); end
    endtask

    task automatic test_wrap();
        logic [15:0] v;
        int n;
        do_reset();
        clear_grid();
        write_row(15, 16'h8000);
        write_row(0, 16'h8000);
        write_row(1, 16'h8000);
        run_gen(n);
        read_row(0, v);
        checks++;
        if (v !== 16'hC001) begin errors++; $display("FAIL wrap_row0 got=%h exp=c001", v); end
        read_row(15, v);
        checks++;
        if (v !== 16'h0000) begin errors++; $display("FAIL wrap_row15 got=%h exp=0000", v); end
        read_row(1, v);
        checks++;
        if (v !== 16'h0000) begin errors++; $display("FAIL wrap_row1 got=%h exp=0000", v); end
    endtask

    task automatic test_glider();
        logic [15:0] v;
        logic [15:0] exp4 [5];
        int n;
        exp4[0] = 16'h0000;
        exp4[1] = 16'h0004;
        exp4[2] = 16'h0008;
        exp4[3] = 16'h000E;
        exp4[4] = 16'h0000;
        do_reset();
        for (int g = 0; g < 4; g++) run_gen(n);
        for (int y = 0; y < 5; y++) begin
            read_row(y, v);
            checks++;
            if (v !== exp4[y]) begin
                errors++;
                $display("FAIL glider4_row%0d got=%h exp=%h", y, v, exp4[y]);
            end
        end
        for (int g = 0; g < 60; g++) run_gen(n);
        for (int y = 0; y < 16; y++) begin
            read_row(y, v);
            checks++;
            if (v !== seed_row(y)) begin
                errors++;
                $display("FAIL glider64_row%0d got=%h exp=%h", y, v, seed_row(y));
            end
        end
        checks++;
        if (gen_count !== 16'd64) begin errors++; $display("FAIL glider_gen got=%0d exp=64", gen_count); end
    endtask

    task automatic test_ignored_mid_calc();
        logic [15:0] v;
        int dones;
        do_reset();
        clear_grid();
        write_row(3, 16'h0038);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        start   = 1'b1;
        wr_en   = 1'b1;
        wr_row  = 4'd3;
        wr_data = 16'hFFFF;
        tick();
        start = 1'b0;
        wr_en = 1'b0;
        dones = 0;
        for (int c = 0; c < 40; c++) begin
            if (done === 1'b1) dones++;
            tick();
        end
        checks++;
        if (dones !== 1) begin errors++; $display("FAIL ignored_done_count got=%0d exp=1", dones); end
        for (int y = 2; y <= 4; y++) begin
            read_row(y, v);
            checks++;
            if (v !== 16'h0010) begin errors++; $display("FAIL ignored_row%0d got=%h exp=0010", y, v); end
        end
        checks++;
        if (gen_count !== 16'd1) begin errors++; $display("FAIL ignored_gen got=%0d exp=1", gen_count); end
    endtask

    task automatic test_write_beats_start();
        logic [15:0] v;
        int busy_seen;
        int done_seen;
        do_reset();
        wr_en   = 1'b1;
        start   = 1'b1;
        wr_row  = 4'd7;
        wr_data = 16'h0100;
        tick();
        wr_en = 1'b0;
        start = 1'b0;
        busy_seen = 0;
        done_seen = 0;
        for (int c = 0; c < 20; c++) begin
            if (busy !== 1'b0) busy_seen++;
            if (done !== 1'b0) done_seen++;
            tick();
        end
        checks++;
        if (busy_seen !== 0) begin errors++; $display("FAIL wrstart_busy got=%0d cycles exp=0", busy_seen); end
        checks++;
        if (done_seen !== 0) begin errors++; $display("FAIL wrstart_done got=%0d cycles exp=0", done_seen); end
        read_row(7, v);
        checks++;
        if (v !== 16'h0100) begin errors++; $display("FAIL wrstart_row7 got=%h exp=0100", v); end
        read_row(2, v);
        checks++;
        if (v !== 16'h0007) begin errors++; $display("FAIL wrstart_row2 got=%h exp=0007", v); end
        checks++;
        if (gen_count !== 16'd0) begin errors++; $display("FAIL wrstart_gen got=%0d exp=0", gen_count); end
    endtask

    task automatic test_reset_mid_calc();
        logic [15:0] v;
        int done_seen;
        do_reset();
        clear_grid();
        write_row(5, 16'h0038);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 7; c++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
        checks++;
        if (gen_count !== 16'd0) begin errors++; $display("FAIL rstmid_gen got=%0d exp=0", gen_count); end
        done_seen = 0;
        for (int c = 0; c < 20; c++) begin
            if (done !== 1'b0) done_seen++;
            tick();
        end
        checks++;
        if (done_seen !== 0) begin errors++; $display("FAIL rstmid_done got=%0d cycles exp=0", done_seen); end
        for (int y = 0; y < 16; y++) begin
            read_row(y, v);
            checks++;
            if (v !== seed_row(y)) begin
                errors++;
                $display("FAIL rstmid_row%0d got=%h exp=%h", y, v, seed_row(y));
            end
        end
    endtask

    task automatic test_extinct();
        logic [15:0] v;
        int n;
        do_reset();
        clear_grid();
        tick();
        checks++;
        if (extinct !== 1'b1) begin errors++; $display("FAIL ext_cleared got=%b exp=1", extinct); end
        write_row(9, 16'h0200);
        checks++;
        if (extinct !== 1'b1) begin errors++; $display("FAIL ext_lag got=%b exp=1", extinct); end
        tick();
        checks++;
        if (extinct !== 1'b0) begin errors++; $display("FAIL ext_after_write got=%b exp=0", extinct); end
        run_gen(n);
        checks++;
        if (extinct !== 1'b1) begin errors++; $display("FAIL ext_after_gen got=%b exp=1", extinct); end
        read_row(9, v);
        checks++;
        if (v !== 16'h0000) begin errors++; $display("FAIL ext_row9 got=%h exp=0000", v); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        tick();
        test_reset();
        test_blinker();
        test_wrap();
        test_glider();
        test_ignored_mid_calc();
        test_write_beats_start();
        test_reset_mid_calc();
        test_extinct();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
